// File: rtl/gdl_psnm.sv
// rtl/gdl_psnm.sv - GDL prescale-and-mask stage with dead-time/busy L1 request gating
//
// Purpose: masks and prescales the FTD trigger bits. When any surviving bit fires in an
// open cycle, it issues a one-cycle L1 request that is stamped with a running event
// number. The stage then enforces dead time until the next request is allowed.
//
// Ports:
//   gclk2        system clock (rising edge)
//   rst          asynchronous active-high reset
//   ftd_bits     FTD trigger bits, valid every cycle
//   psnm_mask    per-bit enable (1 = enabled)
//   psnm_factor  per-bit prescale factor, bit k at [k*PSW +: PSW]
//   psnm_clr     synchronous clear of all prescale counters
//   busy         downstream DAQ busy level
//   l1_req       one-cycle L1 request pulse
//   psnm_bits    bits that passed for the current/last request
//   l1_num       event number of the current/last request
//   dead         high when not IDLE or when busy
module gdl_psnm #(
    parameter int NBIT     = 16,
    parameter int PSW      = 8,
    parameter int DEADTIME = 8
) (
    input  logic                gclk2,
    input  logic                rst,
    input  logic [NBIT-1:0]     ftd_bits,
    input  logic [NBIT-1:0]     psnm_mask,
    input  logic [NBIT*PSW-1:0] psnm_factor,
    input  logic                psnm_clr,
    input  logic                busy,
    output logic                l1_req,
    output logic [NBIT-1:0]     psnm_bits,
    output logic [31:0]         l1_num,
    output logic                dead
);

    localparam int DTW = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;
    localparam logic [DTW-1:0] DT_LOAD = DTW'(DEADTIME - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DEAD  = 2'd1,
        WAITB = 2'd2
    } state_t;

    state_t          state;
    logic [DTW-1:0]  dt_cnt;
    logic [NBIT-1:0] pass;
    logic            open_cyc;

    // Only open cycles see occurrences; a clear wins over any occurrence in its cycle.
    assign open_cyc = (state == IDLE) && !busy && !psnm_clr;
    assign dead     = (state != IDLE) || busy;

    for (genvar k = 0; k < NBIT; k++) begin : g_bit
        logic [PSW-1:0] cnt;
        logic [PSW-1:0] n_fac;
        logic [PSW:0]   inc;
        logic           occ;

        assign n_fac   = psnm_factor[k*PSW +: PSW];
        assign occ     = open_cyc && ftd_bits[k] && psnm_mask[k];
        // One extra bit so cnt+1 cannot wrap before the compare.
        assign inc     = {1'b0, cnt} + (PSW+1)'(1);
        assign pass[k] = occ && (n_fac != '0) && (cnt == '0);

        always_ff @(posedge gclk2 or posedge rst) begin
            if (rst) begin
                cnt <= '0;
            end else if (psnm_clr) begin
                cnt <= '0;
            end else if (occ && (n_fac != '0)) begin
                // Using >= lets a lowered factor wrap immediately instead of counting to 2^PSW.
                cnt <= (inc >= {1'b0, n_fac}) ? '0 : inc[PSW-1:0];
            end
        end
    end

    always_ff @(posedge gclk2 or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            dt_cnt    <= '0;
            l1_req    <= 1'b0;
            psnm_bits <= '0;
            l1_num    <= '0;
        end else begin
            l1_req <= 1'b0;
            case (state)
                IDLE: begin
                    // pass is only ever non-zero while IDLE, so requests are issued here alone.
                    if (|pass) begin
                        l1_req    <= 1'b1;
                        psnm_bits <= pass;
                        l1_num    <= l1_num + 32'd1;
                        dt_cnt    <= DT_LOAD;
                        state     <= DEAD;
                    end
                end
                DEAD: begin
                    if (dt_cnt == '0) begin
                        state <= busy ? WAITB : IDLE;
                    end else begin
                        dt_cnt <= dt_cnt - DTW'(1);
                    end
                end
                WAITB: begin
                    if (!busy) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
